core_maxpooling2d_1_filter3: RTL and testbench
==============================================

# core_maxpooling2d_1_filter3

Streaming 2x2 / stride-2 max-pooling stage placed directly downstream of the conv2d_1 filter-3 feature-map core. It pops one 32-bit IEEE-754 single-precision activation per cycle from that core's output FIFO in raster order, and holds a half-width line buffer of horizontal pair maxima. It pushes one pooled value per 2x2 window into the next layer's input FIFO, with full backpressure and no data loss.

## Interface
- DWIDTH, 32, data width; float32 only.
- IMG_W, 62, input feature-map width in pixels (>= 2).
- IMG_H, 62, input feature-map height in rows (>= 2).
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ff_rdata  in  DWIDTH  head word of the upstream show-ahead FIFO; valid whenever ff_empty=0.
- ff_empty  in  1  upstream FIFO empty.
- ff_rdreq  out  1  pop upstream FIFO; ff_rdata is consumed in the same cycle.
- ff_wdata  out  DWIDTH  pooled value to downstream FIFO.
- ff_wrreq  out  1  write strobe; the write is accepted in any cycle where it is high.
- ff_full  in  1  downstream FIFO full.
- frame_done  out  1  one-cycle pulse when the last pixel of a frame is consumed.

## Operation
- Counters: col 0..IMG_W-1, row 0..IMG_H-1. Both advance only on a pop (pop = ff_rdreq). Both wrap to 0 after pixel (IMG_H-1, IMG_W-1); frame_done pulses in that pop's following cycle.
- Output IMG_W/2 x IMG_H/2 (floor). If IMG_W is odd, the last column is discarded. If IMG_H is odd, the last row is discarded. Discarded pixels are still popped.
- FSM states:
  - ROW_TOP (row even, not the trailing odd row):
    - even col latches pixel into hreg.
    - odd col writes max(hreg, pixel) to linebuf[col>>1].
  - ROW_BOT (row odd):
    - even col latches hreg.
    - odd col computes max(linebuf[col>>1], hreg, pixel) and loads it into the output register.
  - ROW_SKIP (row IMG_H-1 when IMG_H is odd): pop and discard.
- FSM transitions, at col wrap:
  - ROW_TOP -> ROW_BOT.
  - ROW_BOT -> ROW_TOP, or -> ROW_SKIP if the next row is IMG_H-1 and IMG_H is odd.
  - ROW_BOT at frame end -> ROW_TOP.
  - ROW_SKIP -> ROW_TOP.
  - Reset state: ROW_TOP.
- Comparison is float32 sign-magnitude:
  - if the signs differ, the positive operand is larger;
  - if both are positive, the larger magnitude wins;
  - if both are negative, the smaller magnitude wins.
  - -0 and +0 are equal; on ties the earlier operand is kept.
  - NaN/Inf are not produced upstream; their behaviour is unspecified.
- linebuf is IMG_W/2 words and may be registers or inferred RAM; its contents need not be reset.

## Timing
- out_valid flag:
  - set in the cycle after the pop that completes a window;
  - cleared by an accepted write unless a new window completes in the same cycle.
- ff_wrreq = out_valid & ~ff_full. ff_wdata holds the output register and is stable while out_valid=1.
- ff_rdreq = ~reset & ~ff_empty & (~out_valid | ~ff_full). The block never pops when a completing pop could overwrite a pending, unaccepted output.
- Latency: the bottom-right pixel is popped in cycle N, and ff_wrreq is high in cycle N+1 if ff_full=0.
- Throughput: 1 pixel/cycle sustained when the upstream FIFO is never empty and the downstream FIFO is never full.
- A simultaneous accepted write and completing pop is legal: out_valid stays 1 with the new value.
- Reset values, asynchronous and taking effect immediately:
  - ff_wdata=0, ff_wrreq=0, ff_rdreq=0, frame_done=0;
  - out_valid=0, hreg=0, col=row=0, FSM=ROW_TOP.
- Reset mid-frame: the partial frame is abandoned and the pending output is dropped. The next pop after reset release is treated as pixel (0,0).

## Configuration
- MAXPOOL_RELU_EN:
  - When defined, each popped pixel is passed through ReLU before pooling: if the sign bit is set, it is replaced by 32'h00000000, so outputs are never negative.
  - When undefined, raw values are pooled and negative outputs are possible.
  - Counters and timing are identical in both builds.

## Test plan
- 4x4 frame, pixels 1.0..16.0 raster, no stalls -> writes 6.0, 8.0, 14.0, 16.0 in order; frame_done pulses once, 1 cycle after the 16th pop.
- Same frame with ff_full held high for 5 cycles at the first output -> ff_rdreq low during the stall; 6.0 written once when full drops; no loss or duplication.
- IMG_W=5, IMG_H=5, pixels 1.0..25.0 -> outputs 7.0, 9.0, 17.0, 19.0; all 25 pixels popped.
- Window {-3.0, -1.0, -2.0, -0.0} -> -0.0 (32'h80000000) without MAXPOOL_RELU_EN; 32'h00000000 with it.
- Reset asserted after 6 pixels of a 4x4 frame, then a full frame is streamed -> only that frame's 4 correct outputs appear.
- Random empty/full gaps over 3 back-to-back 62x62 frames -> output sequence matches the reference model exactly; 961 writes per frame.

Source files
------------

// File: rtl/core_maxpooling2d_1_filter3_if.sv
// ---------------------------------------------------------------------------
// core_maxpooling2d_1_filter3_if
// Bundles the FIFO-side signals of the 2x2 max-pooling stage.
//   ff_rdata   : head word of the upstream show-ahead FIFO
//   ff_empty   : upstream FIFO empty
//   ff_rdreq   : pop strobe to the upstream FIFO
//   ff_wdata   : pooled value to the downstream FIFO
//   ff_wrreq   : write strobe to the downstream FIFO
//   ff_full    : downstream FIFO full
//   frame_done : one-cycle pulse after the last pixel of a frame is popped
// Modports: slave = pooling core, master = surrounding FIFOs / bench.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
interface core_maxpooling2d_1_filter3_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] ff_rdata;
    logic              ff_empty;
    logic              ff_rdreq;
    logic [DWIDTH-1:0] ff_wdata;
    logic              ff_wrreq;
    logic              ff_full;
    logic              frame_done;

    modport slave (
        input  ff_rdata, ff_empty, ff_full,
        output ff_rdreq, ff_wdata, ff_wrreq, frame_done
    );

    modport master (
        output ff_rdata, ff_empty, ff_full,
        input  ff_rdreq, ff_wdata, ff_wrreq, frame_done
    );
endinterface

// File: rtl/core_maxpooling2d_1_filter3.sv
// ---------------------------------------------------------------------------
// core_maxpooling2d_1_filter3
// Streaming 2x2 / stride-2 float32 max-pooling stage. Pops one activation per
// cycle in raster order, keeps a half-width line buffer of horizontal pair
// maxima from the even row, and emits one pooled value per 2x2 window.
// Odd trailing column / row are popped and discarded.
//
// Ports:
//   i_clock : clock, all state on the rising edge
//   i_reset : asynchronous active-high reset
//   io_bus  : FIFO handshake bundle (slave modport), see the interface file
//
// Optional build macro: MAXPOOL_RELU_EN -- apply ReLU to every popped pixel
// before pooling (negative inputs become +0).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module core_maxpooling2d_1_filter3 #(
    parameter int DWIDTH = 32,
    parameter int IMG_W  = 62,
    parameter int IMG_H  = 62
) (
    input  logic                         i_clock,
    input  logic                         i_reset,
    core_maxpooling2d_1_filter3_if.slave io_bus
);

    localparam int OUT_W = IMG_W / 2;
    localparam int CW    = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW    = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LBW   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam bit H_ODD = (IMG_H % 2) == 1;

    typedef enum logic [1:0] {
        ROW_TOP  = 2'd0,
        ROW_BOT  = 2'd1,
        ROW_SKIP = 2'd2
    } state_t;

    // b strictly greater than a, sign-magnitude float order with -0 == +0.
    function automatic logic f_gt(input logic [DWIDTH-1:0] a,
                                  input logic [DWIDTH-1:0] b);
        logic a_zero;
        logic b_zero;
        a_zero = (a[DWIDTH-2:0] == '0);
        b_zero = (b[DWIDTH-2:0] == '0);
        if (a_zero && b_zero)
            return 1'b0;
        if (a[DWIDTH-1] != b[DWIDTH-1])
            return ~b[DWIDTH-1];
        if (!b[DWIDTH-1])
            return b[DWIDTH-2:0] > a[DWIDTH-2:0];
        return b[DWIDTH-2:0] < a[DWIDTH-2:0];
    endfunction

    // Earlier operand wins ties, so -0/+0 ordering follows arrival order.
    function automatic logic [DWIDTH-1:0] f_max(input logic [DWIDTH-1:0] a,
                                                 input logic [DWIDTH-1:0] b);
        return f_gt(a, b) ? b : a;
    endfunction

    state_t            r_state;
    state_t            w_next_state;
    logic [CW-1:0]     r_col;
    logic [RW-1:0]     r_row;
    logic [DWIDTH-1:0] r_hreg;
    logic [DWIDTH-1:0] r_out_data;
    logic              r_out_valid;
    logic              r_frame_done;
    logic [DWIDTH-1:0] r_linebuf [OUT_W];

    logic              w_pop;
    logic [DWIDTH-1:0] w_pix;
    logic              w_col_last;
    logic              w_row_last;
    logic              w_col_pair;
    logic              w_hreg_load;
    logic              w_lb_write;
    logic              w_win_done;
    logic [LBW-1:0]    w_lb_idx;
    logic [DWIDTH-1:0] w_lb_rd;
    logic [DWIDTH-1:0] w_hmax;
    logic [DWIDTH-1:0] w_wmax;

    // A pop is blocked only while a finished window is still waiting on a
    // full downstream FIFO, so a completing pop can never clobber it.
    assign w_pop = ~i_reset & ~io_bus.ff_empty & (~r_out_valid | ~io_bus.ff_full);

`ifdef MAXPOOL_RELU_EN
    assign w_pix = io_bus.ff_rdata[DWIDTH-1] ? '0 : io_bus.ff_rdata;
`else
    assign w_pix = io_bus.ff_rdata;
`endif

    assign w_col_last = (r_col == CW'(IMG_W - 1));
    assign w_row_last = (r_row == RW'(IMG_H - 1));
    // Excludes the trailing column of an odd-width frame.
    assign w_col_pair = ({1'b0, r_col} < (CW+1)'(2 * OUT_W));
    assign w_lb_idx   = LBW'(r_col >> 1);
    assign w_lb_rd    = r_linebuf[w_lb_idx];
    assign w_hmax     = f_max(r_hreg, w_pix);
    assign w_wmax     = f_max(f_max(w_lb_rd, r_hreg), w_pix);

    // ---------------- pixel position counters ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_pop) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_state <= ROW_TOP;
        else
            r_state <= w_next_state;
    end

    // ---------------- FSM: next state (changes only at column wrap) ----
    always_comb begin
        w_next_state = r_state;
        if (w_pop && w_col_last) begin
            case (r_state)
                ROW_TOP:  w_next_state = ROW_BOT;
                // Next row is the trailing odd row only when it is IMG_H-1.
                ROW_BOT:  w_next_state = (H_ODD && !w_row_last && (r_row == RW'(IMG_H - 2)))
                                         ? ROW_SKIP : ROW_TOP;
                default:  w_next_state = ROW_TOP;
            endcase
        end
    end

    // ---------------- FSM: datapath controls ----------------
    always_comb begin
        w_hreg_load = 1'b0;
        w_lb_write  = 1'b0;
        w_win_done  = 1'b0;
        case (r_state)
            ROW_TOP: begin
                w_hreg_load = w_pop & ~r_col[0] & w_col_pair;
                w_lb_write  = w_pop &  r_col[0];
            end
            ROW_BOT: begin
                w_hreg_load = w_pop & ~r_col[0] & w_col_pair;
                w_win_done  = w_pop &  r_col[0];
            end
            default: ;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_hreg <= '0;
        else if (w_hreg_load)
            r_hreg <= w_pix;
    end

    // Line buffer holds no state that matters across reset: every entry is
    // rewritten by the top row before the bottom row reads it.
    always_ff @(posedge i_clock) begin
        if (w_lb_write)
            r_linebuf[w_lb_idx] <= w_hmax;
    end

    // A completing window wins over an accepted write in the same cycle,
    // keeping out_valid high with the new value.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_win_done) begin
            r_out_data  <= w_wmax;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && !io_bus.ff_full) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)
            r_frame_done <= 1'b0;
        else
            r_frame_done <= w_pop & w_col_last & w_row_last;
    end

    assign io_bus.ff_rdreq    = w_pop;
    assign io_bus.ff_wrreq    = r_out_valid & ~io_bus.ff_full;
    assign io_bus.ff_wdata    = r_out_data;
    assign io_bus.frame_done  = r_frame_done;

endmodule

// File: tb/tb_core_maxpooling2d_1_filter3.sv
// ---------------------------------------------------------------------------
// tb_core_maxpooling2d_1_filter3
// Three pooling instances (4x4, 5x5, 62x62) share one clock and reset.
// Stimulus pushes pixels into per-instance source queues and expected pooled
// values into per-instance scoreboard queues; a negedge monitor compares every
// write, frame_done pulse, write latency, stall behaviour and reset outputs.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_core_maxpooling2d_1_filter3;

    localparam int NK = 3;
    localparam int WS [NK] = '{4, 5, 62};
    localparam int HS [NK] = '{4, 5, 62};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_maxpooling2d_1_filter3_if #(.DWIDTH(32)) bus0 ();
    core_maxpooling2d_1_filter3_if #(.DWIDTH(32)) bus1 ();
    core_maxpooling2d_1_filter3_if #(.DWIDTH(32)) bus2 ();

    core_maxpooling2d_1_filter3 #(.DWIDTH(32), .IMG_W(4),  .IMG_H(4))
        u_dut0 (.i_clock(clk), .i_reset(rst), .io_bus(bus0));
    core_maxpooling2d_1_filter3 #(.DWIDTH(32), .IMG_W(5),  .IMG_H(5))
        u_dut1 (.i_clock(clk), .i_reset(rst), .io_bus(bus1));
    core_maxpooling2d_1_filter3 #(.DWIDTH(32), .IMG_W(62), .IMG_H(62))
        u_dut2 (.i_clock(clk), .i_reset(rst), .io_bus(bus2));

    logic [NK-1:0][31:0] drv_rdata = '0;
    logic [NK-1:0]       drv_empty = '1;
    logic [NK-1:0]       drv_full  = '0;
    wire  [NK-1:0]       mon_rdreq, mon_wrreq, mon_done;
    wire  [NK-1:0][31:0] mon_wdata;

    assign bus0.ff_rdata = drv_rdata[0];
    assign bus0.ff_empty = drv_empty[0];
    assign bus0.ff_full  = drv_full[0];
    assign bus1.ff_rdata = drv_rdata[1];
    assign bus1.ff_empty = drv_empty[1];
    assign bus1.ff_full  = drv_full[1];
    assign bus2.ff_rdata = drv_rdata[2];
    assign bus2.ff_empty = drv_empty[2];
    assign bus2.ff_full  = drv_full[2];
    assign mon_rdreq[0] = bus0.ff_rdreq;
    assign mon_wrreq[0] = bus0.ff_wrreq;
    assign mon_wdata[0] = bus0.ff_wdata;
    assign mon_done[0]  = bus0.frame_done;
    assign mon_rdreq[1] = bus1.ff_rdreq;
    assign mon_wrreq[1] = bus1.ff_wrreq;
    assign mon_wdata[1] = bus1.ff_wdata;
    assign mon_done[1]  = bus1.frame_done;
    assign mon_rdreq[2] = bus2.ff_rdreq;
    assign mon_wrreq[2] = bus2.ff_wrreq;
    assign mon_wdata[2] = bus2.ff_wdata;
    assign mon_done[2]  = bus2.frame_done;

    // Source and scoreboard queues are only pushed by stimulus; the driver and
    // monitor walk them with their own read indices.
    logic [31:0] srcq [NK][$];
    logic [31:0] expq [NK][$];
    int          src_rd [NK] = '{default: 0};
    int          exp_rd [NK] = '{default: 0};
    int          wr_cnt [NK] = '{default: 0};
    int          pos    [NK] = '{default: 0};

    bit [NK-1:0] full_force = '0;
    bit [NK-1:0] rand_en    = '0;
    bit [NK-1:0] lat_chk    = '0;
    bit [NK-1:0] stall_chk  = '0;
    bit [NK-1:0] rd_seen    = '0;
    bit [NK-1:0] exp_done   = '0;
    bit [NK-1:0] win_prev   = '0;
    bit          fin        = 1'b0;
    bit          fin_done   = 1'b0;
    int          tmo_cnt    = 0;
    int          tmo_seen   = 0;
    int          n_tests    = 0;
    int          n_fail     = 0;

    logic [31:0] fr [62][62];

    // ---------------- reference helpers ----------------
    function automatic logic [31:0] i2f(input int n);
        int p;
        logic [31:0] m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 31; i++) if ((n >> i) != 0) p = i;
        m = (n << (23 - p)) & 32'h007F_FFFF;
        return {1'b0, 8'(127 + p), m[22:0]};
    endfunction

    // Total order key: sign-magnitude to signed integer; -0 maps onto +0.
    function automatic longint fkey(input logic [31:0] x);
        longint m;
        m = longint'(x[30:0]);
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] rmax(input logic [31:0] a, input logic [31:0] b);
        return (fkey(b) > fkey(a)) ? b : a;
    endfunction

    function automatic logic [31:0] relu_m(input logic [31:0] x);
`ifdef MAXPOOL_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input int k, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", k, nm, act, exp, $time);
        end
    endtask

    // ---------------- upstream / downstream FIFO models ----------------
    always @(posedge clk) begin
        bit gap;
        #1;
        for (int k = 0; k < NK; k++) begin
            if (rd_seen[k] && src_rd[k] < srcq[k].size()) src_rd[k]++;
            gap = rand_en[k] && ($urandom_range(0, 3) == 0);
            drv_empty[k] = (src_rd[k] >= srcq[k].size()) || gap;
            drv_rdata[k] = (src_rd[k] < srcq[k].size()) ? srcq[k][src_rd[k]] : 32'h0;
            drv_full[k]  = rand_en[k] ? ($urandom_range(0, 3) == 0) : full_force[k];
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        int r, c;
        for (int k = 0; k < NK; k++) begin
            if (rst) begin
                chk(k, "reset_rdreq", 32'(mon_rdreq[k]), 32'h0);
                chk(k, "reset_wrreq", 32'(mon_wrreq[k]), 32'h0);
                chk(k, "reset_wdata", mon_wdata[k], 32'h0);
                chk(k, "reset_done",  32'(mon_done[k]), 32'h0);
                pos[k] = 0;
                rd_seen[k] = 1'b0;
                exp_done[k] = 1'b0;
                win_prev[k] = 1'b0;
            end else begin
                if (mon_wrreq[k]) begin
                    wr_cnt[k]++;
                    if (exp_rd[k] < expq[k].size()) begin
                        chk(k, "wdata", mon_wdata[k], expq[k][exp_rd[k]]);
                        exp_rd[k]++;
                    end else begin
                        chk(k, "extra_write", 32'(wr_cnt[k]), 32'(expq[k].size()));
                    end
                end
                if (exp_done[k] || mon_done[k])
                    chk(k, "frame_done", 32'(mon_done[k]), 32'(exp_done[k]));
                if (lat_chk[k] && (win_prev[k] || mon_wrreq[k]))
                    chk(k, "write_latency", 32'(mon_wrreq[k]), 32'(win_prev[k]));
                if (stall_chk[k]) begin
                    chk(k, "stall_rdreq", 32'(mon_rdreq[k]), 32'h0);
                    chk(k, "stall_wrreq", 32'(mon_wrreq[k]), 32'h0);
                end
                rd_seen[k]  = mon_rdreq[k];
                exp_done[k] = 1'b0;
                win_prev[k] = 1'b0;
                if (mon_rdreq[k]) begin
                    r = pos[k] / WS[k];
                    c = pos[k] % WS[k];
                    exp_done[k] = (pos[k] == WS[k] * HS[k] - 1);
                    win_prev[k] = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (HS[k] / 2));
                    pos[k] = (pos[k] + 1) % (WS[k] * HS[k]);
                end
            end
        end
        if (tmo_cnt != tmo_seen) begin
            chk(0, "wait_timeout", 32'(tmo_cnt), 32'(tmo_seen));
            tmo_seen = tmo_cnt;
        end
        if (fin && !fin_done) begin
            for (int k = 0; k < NK; k++) begin
                chk(k, "expected_drained", 32'(exp_rd[k]), 32'(expq[k].size()));
                chk(k, "pixels_popped",    32'(src_rd[k]), 32'(srcq[k].size()));
                chk(k, "write_count",      32'(wr_cnt[k]), 32'(expq[k].size()));
            end
            fin_done = 1'b1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic push_ramp(input int k, input int n);
        for (int i = 1; i <= n; i++) srcq[k].push_back(i2f(i));
    endtask

    task automatic wait_idle(input int k, input int lim);
        int t;
        t = 0;
        while ((src_rd[k] < srcq[k].size() || exp_rd[k] < expq[k].size()) && t < lim) begin
            @(negedge clk);
            t++;
        end
        if (t >= lim) tmo_cnt++;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [31:0] prev;
        logic [31:0] m;
        int t;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);

        // 4x4 ramp, no stalls
        lat_chk[0] = 1'b1;
        push_ramp(0, 16);
        expq[0].push_back(i2f(6));
        expq[0].push_back(i2f(8));
        expq[0].push_back(i2f(14));
        expq[0].push_back(i2f(16));
        wait_idle(0, 200);

        // same frame, downstream full until the first output is pending
        lat_chk[0] = 1'b0;
        full_force[0] = 1'b1;
        push_ramp(0, 16);
        expq[0].push_back(i2f(6));
        expq[0].push_back(i2f(8));
        expq[0].push_back(i2f(14));
        expq[0].push_back(i2f(16));
        t = 0;
        while (!(src_rd[0] >= 16 + 6 && !mon_rdreq[0]) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) tmo_cnt++;
        stall_chk[0] = 1'b1;
        repeat (5) @(negedge clk);
        stall_chk[0] = 1'b0;
        full_force[0] = 1'b0;
        wait_idle(0, 200);

        // negative / signed-zero window in the top-left corner
        lat_chk[0] = 1'b1;
        srcq[0].push_back(32'hC040_0000);   // -3.0
        srcq[0].push_back(32'hBF80_0000);   // -1.0
        srcq[0].push_back(i2f(3));
        srcq[0].push_back(i2f(4));
        srcq[0].push_back(32'hC000_0000);   // -2.0
        srcq[0].push_back(32'h8000_0000);   // -0.0
        srcq[0].push_back(i2f(7));
        srcq[0].push_back(i2f(8));
        for (int i = 9; i <= 16; i++) srcq[0].push_back(i2f(i));
`ifdef MAXPOOL_RELU_EN
        expq[0].push_back(32'h0000_0000);
`else
        expq[0].push_back(32'h8000_0000);
`endif
        expq[0].push_back(i2f(8));
        expq[0].push_back(i2f(14));
        expq[0].push_back(i2f(16));
        wait_idle(0, 200);

        // reset after 6 pixels with the first window still pending
        lat_chk[0] = 1'b0;
        full_force[0] = 1'b1;
        push_ramp(0, 6);
        t = 0;
        while (src_rd[0] < srcq[0].size() && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) tmo_cnt++;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        full_force[0] = 1'b0;
        @(negedge clk);
        push_ramp(0, 16);
        expq[0].push_back(i2f(6));
        expq[0].push_back(i2f(8));
        expq[0].push_back(i2f(14));
        expq[0].push_back(i2f(16));
        wait_idle(0, 200);

        // 5x5: trailing column and row discarded
        lat_chk[1] = 1'b1;
        push_ramp(1, 25);
        expq[1].push_back(i2f(7));
        expq[1].push_back(i2f(9));
        expq[1].push_back(i2f(17));
        expq[1].push_back(i2f(19));
        wait_idle(1, 300);

        // 62x62: three back-to-back random frames with random empty/full gaps
        rand_en[2] = 1'b1;
        prev = 32'h3F80_0000;
        for (int f = 0; f < 3; f++) begin
            for (int r = 0; r < 62; r++) begin
                for (int c = 0; c < 62; c++) begin
                    case ($urandom_range(0, 9))
                        0:       fr[r][c] = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
                        1:       fr[r][c] = prev;
                        default: fr[r][c] = {1'($urandom_range(0, 1)), 8'($urandom_range(120, 134)),
                                             23'($urandom)};
                    endcase
                    prev = fr[r][c];
                    srcq[2].push_back(fr[r][c]);
                end
            end
            for (int orow = 0; orow < 31; orow++) begin
                for (int ocol = 0; ocol < 31; ocol++) begin
                    m = rmax(relu_m(fr[2*orow][2*ocol]), relu_m(fr[2*orow][2*ocol+1]));
                    m = rmax(m, relu_m(fr[2*orow+1][2*ocol]));
                    m = rmax(m, relu_m(fr[2*orow+1][2*ocol+1]));
                    expq[2].push_back(m);
                end
            end
        end
        wait_idle(2, 60000);
        rand_en[2] = 1'b0;

        fin = 1'b1;
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
